// File: rtl/pci_pkg.sv
// Shared types and defaults for the PCI segment arbiter.
package pci_pkg;

   typedef enum logic [1:0] {
      PARK  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      DEAD  = 2'd3
   } arb_state_t;

   localparam int unsigned PCI_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pci_arbiter_rr_picker.sv
// Combinational round-robin search: first unmasked requester above 'last', wrapping.
module rr_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         logic [IW-1:0] c;
         c = IW'((32'(last) + k) % N);
         if (!any && req[c] && !mask[c]) begin
            any       = 1'b1;
            grant_idx = c;
         end
      end
   end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI REQ#/GNT# arbiter: round-robin, hidden arbitration, parking,
// one-clock handover gap and revocation of grants that never start.
module pci_arbiter
   import pci_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = PCI_TIMEOUT_DEF,
   parameter bit          PARK_EN = 1'b1,
   parameter int unsigned PARK_ID = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N-1:0]         REQ_N,
   input  logic                 FRAME,
   input  logic                 IRDY,
   output logic [N-1:0]         GNT_N,
   output logic [$clog2(N)-1:0] OWNER,
   output logic                 TIMEOUT_ERR
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   arb_state_t    state_q, state_d;
   logic [N-1:0]  gnt_n_q, gnt_n_d;
   logic [IW-1:0] owner_q, owner_d;
   logic          tmo_err_q, tmo_err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          idle_q, idle_d;
   logic [N-1:0]  skip_q, skip_d;

   logic [N-1:0]  req;
   logic [N-1:0]  owner_oh;
   logic [IW-1:0] win_idx;
   logic          win_any;
   logic          start;
   logic [CW-1:0] cnt_inc;
   logic          tmo;

   assign req      = ~REQ_N;
   assign owner_oh = N'(1) << owner_q;
   assign start    = !FRAME && idle_q;
   assign cnt_inc  = cnt_q + CW'(idle_q);
   assign tmo      = (cnt_inc == CW'(TIMEOUT));

   rr_picker #(.N(N), .IW(IW)) u_picker (
      .req       (req),
      .last      (owner_q),
      .mask      (skip_q),
      .grant_idx (win_idx),
      .any       (win_any)
   );

   // Next state; the grant vector is derived from where the FSM is going.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      tmo_err_d = 1'b0;
      skip_d    = skip_q;
      idle_d    = FRAME && IRDY;
      gnt_n_d   = '1;

      case (state_q)
         PARK: begin
            if (win_any) begin
               if (!PARK_EN || (win_idx == IW'(PARK_ID))) begin
                  state_d = GRANT;
                  owner_d = win_idx;
                  cnt_d   = '0;
               end else begin
                  state_d = DEAD;
               end
            end
         end
         GRANT: begin
            if (tmo) begin
               state_d   = DEAD;
               tmo_err_d = 1'b1;
               skip_d    = owner_oh;
            end else if (start) begin
               state_d = BUSY;
            end else if (!req[owner_q]) begin
               state_d = DEAD;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         BUSY: begin
            if ((req & ~owner_oh) != '0) begin
               state_d = DEAD;
            end else if (FRAME && IRDY) begin
               state_d = GRANT;
               cnt_d   = '0;
            end
         end
         DEAD: begin
            skip_d = '0;
            if (win_any) begin
               state_d = GRANT;
               owner_d = win_idx;
               cnt_d   = '0;
            end else begin
               state_d = PARK;
            end
         end
         default: state_d = PARK;
      endcase

      case (state_d)
         GRANT, BUSY: gnt_n_d = ~(N'(1) << owner_d);
         PARK:        gnt_n_d = PARK_EN ? ~(N'(1) << PARK_ID) : '1;
         default:     gnt_n_d = '1;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= PARK;
         gnt_n_q   <= '1;
         owner_q   <= IW'(PARK_ID);
         tmo_err_q <= 1'b0;
         cnt_q     <= '0;
         idle_q    <= 1'b1;
         skip_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_n_q   <= gnt_n_d;
         owner_q   <= owner_d;
         tmo_err_q <= tmo_err_d;
         cnt_q     <= cnt_d;
         idle_q    <= idle_d;
         skip_q    <= skip_d;
      end
   end

   assign GNT_N       = gnt_n_q;
   assign OWNER       = owner_q;
   assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: directed scenarios plus random traffic
// against a behavioural model of the arbitration rules.
module tb_pci_arbiter;

   localparam int N       = 4;
   localparam int TMO     = 16;
   localparam int PARK_ID = 0;
   localparam bit PARK_EN = 1'b1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_n;
   logic       frame;
   logic       irdy;
   logic [3:0] gnt_n;
   logic [1:0] owner;
   logic       terr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pci_arbiter #(.N(N), .TIMEOUT(TMO), .PARK_EN(PARK_EN), .PARK_ID(PARK_ID)) dut (
      .CLK         (clk),
      .RST         (rst),
      .REQ_N       (req_n),
      .FRAME       (frame),
      .IRDY        (irdy),
      .GNT_N       (gnt_n),
      .OWNER       (owner),
      .TIMEOUT_ERR (terr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      if (obs !== want) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, want);
      end
   endtask

   // Reference model: who holds the bus, whether a transaction runs, and
   // whether this clock is a forced all-high gap.
   int m_hold, m_owner, m_wait, m_skip, prev_low;
   bit m_gap, m_busy, m_idle, m_err, m_fresh, last_fr;

   function automatic int pick(input logic [3:0] rn, input int from, input int skip);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (from + k) % N;
         if (c != skip && rn[c] == 1'b0) return c;
      end
      return -1;
   endfunction

   function automatic int low_idx(input logic [3:0] g);
      for (int i = 0; i < N; i++) if (!g[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_hold = -1; m_owner = PARK_ID; m_wait = 0; m_skip = -1;
      m_gap = 0; m_busy = 0; m_idle = 1; m_err = 0; m_fresh = 1; prev_low = -1;
   endtask

   task automatic model_edge(input logic [3:0] rn, input logic fr, input logic ir);
      int w;
      bit was_idle, start;
      was_idle = m_idle;
      start    = !fr && was_idle;
      m_err    = 0;
      m_fresh  = 0;
      if (m_gap) begin
         m_gap  = 0;
         w      = pick(rn, m_owner, m_skip);
         m_skip = -1;
         if (w >= 0) begin m_hold = w; m_owner = w; m_wait = 0; m_busy = 0; end
         else m_hold = -1;
      end else if (m_hold < 0) begin
         w = pick(rn, m_owner, -1);
         if (w >= 0) begin
            if (!PARK_EN || w == PARK_ID) begin m_hold = w; m_owner = w; m_wait = 0; m_busy = 0; end
            else m_gap = 1;
         end
      end else if (!m_busy) begin
         if (was_idle) m_wait++;
         if (m_wait == TMO) begin m_err = 1; m_skip = m_hold; m_gap = 1; m_hold = -1; end
         else if (start) m_busy = 1;
         else if (rn[m_hold]) begin m_gap = 1; m_hold = -1; end
      end else begin
         if ((~rn & ~(4'b0001 << m_hold)) != 4'b0000) begin m_gap = 1; m_hold = -1; m_busy = 0; end
         else if (fr && ir) begin m_busy = 0; m_wait = 0; end
      end
      m_idle = fr && ir;
   endtask

   function automatic logic [3:0] exp_gnt();
      if (m_fresh || m_gap) return 4'hF;
      if (m_hold >= 0) return ~(4'b0001 << m_hold);
      return PARK_EN ? ~(4'b0001 << PARK_ID) : 4'hF;
   endfunction

   task automatic step();
      int cur;
      @(posedge clk);
      model_edge(req_n, frame, irdy);
      last_fr = frame;
      #1;
      chk("gnt", 32'(gnt_n), 32'(exp_gnt()));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("timeout_err", 32'(terr), 32'(m_err));
      chk("onehot", 32'($countones(~gnt_n) <= 1), 32'(1));
      cur = low_idx(gnt_n);
      chk("handover_gap", 32'(!(cur >= 0 && prev_low >= 0 && cur != prev_low)), 32'(1));
      prev_low = cur;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_n = 4'hF; frame = 1'b1; irdy = 1'b1; last_fr = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt_n), 32'hF);
      chk("rst_owner", 32'(owner), 32'(PARK_ID));
      rst = 1'b0;
   endtask

   initial begin
      int order[$];
      int low, errs;
      bit found;
      rst = 1'b1; req_n = 4'hF; frame = 1'b1; irdy = 1'b1;

      // Reset and first park grant
      do_reset();
      step();
      chk("t1_park", 32'(gnt_n), 32'hE);
      chk("t1_owner", 32'(owner), 32'd0);

      // Master 2 from PARK goes through a gap, then holds through a transaction
      req_n = 4'b1011;
      step(); chk("t2_gap", 32'(gnt_n), 32'hF);
      step(); chk("t2_gnt", 32'(gnt_n), 32'hB); chk("t2_owner", 32'(owner), 32'd2);
      step(); step();
      frame = 1'b0;
      repeat (3) step();
      chk("t2_held", 32'(gnt_n), 32'hB);

      // Asynchronous reset in the middle of master 2's transaction
      #2 rst = 1'b1;
      #1;
      chk("t6_gnt", 32'(gnt_n), 32'hF);
      chk("t6_owner", 32'(owner), 32'd0);
      chk("t6_terr", 32'(terr), 32'd0);
      model_reset();
      req_n = 4'hF; frame = 1'b1; irdy = 1'b1; last_fr = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      step(); chk("t6_park", 32'(gnt_n), 32'hE);

      // All masters requesting, each runs one 3-clock transaction
      req_n = 4'b0000;
      step();
      for (int t = 0; t < 5; t++) begin
         found = 0;
         for (int c = 0; c < 40 && !found; c++) begin
            if (gnt_n != 4'hF && last_fr) found = 1;
            else step();
         end
         chk("t3_found", 32'(found), 32'd1);
         if (found) begin
            order.push_back(low_idx(gnt_n));
            chk("t3_order", 32'(order[t]), 32'((t + 1) % N));
            frame = 1'b0;
            repeat (3) step();
            frame = 1'b1;
            step();
         end
      end
      req_n = 4'hF;
      repeat (3) step();

      // Master 1 granted but never starts; master 3 waiting
      do_reset();
      step();
      req_n = 4'b0101;
      step(); step();
      chk("t4_gnt", 32'(gnt_n), 32'hD);
      low = 1; errs = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (terr) begin
            errs++;
            chk("t4_gnt_at_err", 32'(gnt_n), 32'hF);
            break;
         end
         if (gnt_n == 4'hD) low++;
      end
      chk("t4_low_cycles", 32'(low), 32'(TMO));
      chk("t4_err_pulses", 32'(errs), 32'd1);
      step();
      chk("t4_next", 32'(gnt_n), 32'h7);
      chk("t4_err_clear", 32'(terr), 32'd0);
      req_n = 4'hF;
      repeat (3) step();

      // Hidden arbitration: master 0 busy, master 3 requests
      do_reset();
      step();
      req_n = 4'b1110;
      step(); chk("t5_gnt0", 32'(gnt_n), 32'hE);
      frame = 1'b0;
      step();
      req_n = 4'b0110;
      step(); chk("t5_gap", 32'(gnt_n), 32'hF);
      step(); chk("t5_gnt3", 32'(gnt_n), 32'h7);
      repeat (3) begin step(); chk("t5_wait_idle", 32'(gnt_n), 32'h7); end
      req_n = 4'b0111; frame = 1'b1;
      step();
      frame = 1'b0;
      step(); step();
      chk("t5_busy3", 32'(gnt_n), 32'h7);
      frame = 1'b1; req_n = 4'hF;
      repeat (3) step();

      // Random traffic against the model
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) req_n = 4'($urandom);
         if ($urandom_range(0, 4) == 0) frame = ~frame;
         irdy = frame ? ($urandom_range(0, 5) != 0) : 1'($urandom_range(0, 1));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
